// File: rtl/dcfifo.sv
// ---------------------------------------------------------------------------
// dcfifo: single-clock FIFO with registered occupancy flags.
//
// Storage is a DEPTH-entry array addressed by wrapping write/read pointers.
// Occupancy (o_usedw) and the o_wrfull/o_rdempty flags are registers that
// reflect the state after each edge, so a word written at one edge can be
// read by an rdreq sampled at the next edge.
//
// Optional feature macro: DCFIFO_SHOWAHEAD_EN
//   undefined : normal mode. o_q is a register loaded with the head word at
//               the edge that accepts a read, and held until the next read.
//   defined   : show-ahead mode. o_q presents the head word whenever the FIFO
//               is not empty, and 0 while empty. i_rdreq acknowledges the
//               current head word.
//
// Ports
//   i_clock   in   1              clock; all logic on the rising edge
//   i_aclr    in   1              synchronous active-high clear
//   i_wrreq   in   1              write request
//   i_data    in   WIDTH          write data
//   o_wrfull  out  1              occupancy == DEPTH
//   i_rdreq   in   1              read request / acknowledge
//   o_q       out  WIDTH          read data
//   o_rdempty out  1              occupancy == 0
//   o_usedw   out  $clog2(DEPTH)+1 occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module dcfifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic                     i_clock,
    input  logic                     i_aclr,
    input  logic                     i_wrreq,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_wrfull,
    input  logic                     i_rdreq,
    output logic [WIDTH-1:0]         o_q,
    output logic                     o_rdempty,
    output logic [$clog2(DEPTH):0]   o_usedw
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_usedw;
    logic             r_full;
    logic             r_empty;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [AW:0]      w_usedw_d;

    // Requests are qualified by the registered flags, so a write while full or
    // a read while empty has no effect even if the other side is active.
    assign w_wr_acc = i_wrreq & ~r_full;
    assign w_rd_acc = i_rdreq & ~r_empty;

    always_comb begin
        w_usedw_d = r_usedw;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_usedw_d = r_usedw + (AW + 1)'(1);
            2'b01:   w_usedw_d = r_usedw - (AW + 1)'(1);
            default: w_usedw_d = r_usedw;
        endcase
    end

    // Contents need no reset: clearing the pointers discards them.
    always_ff @(posedge i_clock) begin
        if (!i_aclr && w_wr_acc) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_aclr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usedw <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_usedw <= w_usedw_d;
            // Flags are computed from next-state occupancy: no added latency.
            r_full  <= (w_usedw_d == FULL_CNT);
            r_empty <= (w_usedw_d == '0);
        end
    end

`ifdef DCFIFO_SHOWAHEAD_EN
    // Head word is visible directly; forced to 0 while empty so stale
    // contents never appear after a clear.
    assign o_q = r_empty ? '0 : r_mem[r_rptr];
`else
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clock) begin
        if (i_aclr) begin
            r_q <= '0;
        end else if (w_rd_acc) begin
            r_q <= r_mem[r_rptr];
        end
    end

    assign o_q = r_q;
`endif

    assign o_wrfull  = r_full;
    assign o_rdempty = r_empty;
    assign o_usedw   = r_usedw;

endmodule

// File: tb/tb_dcfifo.sv
// ---------------------------------------------------------------------------
// tb_dcfifo: directed self-checking bench for dcfifo (WIDTH=32, DEPTH=512).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. after the edge they reflect.
// ---------------------------------------------------------------------------
module tb_dcfifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 512;

    logic                 clk;
    logic                 aclr;
    logic                 wrreq;
    logic [WIDTH-1:0]     data;
    logic                 wrfull;
    logic                 rdreq;
    logic [WIDTH-1:0]     q;
    logic                 rdempty;
    logic [$clog2(DEPTH):0] usedw;

    int n_tests;
    int n_fail;

    dcfifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .i_clock   (clk),
        .i_aclr    (aclr),
        .i_wrreq   (wrreq),
        .i_data    (data),
        .o_wrfull  (wrfull),
        .i_rdreq   (rdreq),
        .o_q       (q),
        .o_rdempty (rdempty),
        .o_usedw   (usedw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net; the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wrreq = 1'b0;
        rdreq = 1'b0;
        aclr  = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        wrreq = 1'b1;
        data  = v;
        tick();
        wrreq = 1'b0;
    endtask

    task automatic pop();
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
    endtask

    logic [31:0] vec029 [4];
    logic [31:0] vec030 [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        data    = '0;
        idle();
        vec029 = '{32'd2, 32'd3, 32'd0, 32'd0};
        vec030 = '{32'd4, 32'd16, 32'd16, 32'd16};

        // Reset.
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        check("rst_usedw", 32'(usedw), 32'd0);
        check("rst_rdempty", 32'(rdempty), 32'd1);
        check("rst_wrfull", 32'(wrfull), 32'd0);
        check("rst_q", q, 32'd0);

`ifdef DCFIFO_SHOWAHEAD_EN
        // Head word visible without a read; rdreq advances to the next word.
        push(32'hA);
        check("sa_q_after_a", q, 32'hA);
        push(32'hB);
        check("sa_q_after_b", q, 32'hA);
        check("sa_usedw2", 32'(usedw), 32'd2);
        pop();
        check("sa_q_next", q, 32'hB);
        check("sa_usedw1", 32'(usedw), 32'd1);
        pop();
        check("sa_q_empty", q, 32'd0);
        check("sa_rdempty", 32'(rdempty), 32'd1);
        // Clear with data stored: q returns to 0.
        push(32'h5);
        check("sa_q_c", q, 32'h5);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        check("sa_clr_q", q, 32'd0);
        check("sa_clr_usedw", 32'(usedw), 32'd0);
`else
        // Four writes, then four single-cycle reads.
        for (int i = 0; i < 4; i++) push(vec029[i]);
        check("w4_usedw", 32'(usedw), 32'd4);
        check("w4_rdempty", 32'(rdempty), 32'd0);
        check("w4_wrfull", 32'(wrfull), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pop();
            check($sformatf("r4_q%0d", i), q, vec029[i]);
            tick();
        end
        check("r4_rdempty", 32'(rdempty), 32'd1);
        check("r4_usedw", 32'(usedw), 32'd0);

        // Streaming: each word read on the cycle after its write.
        wrreq = 1'b1;
        data  = vec030[0];
        tick();
        check("st_usedw0", 32'(usedw), 32'd1);
        for (int i = 1; i < 4; i++) begin
            wrreq = 1'b1;
            rdreq = 1'b1;
            data  = vec030[i];
            tick();
            check($sformatf("st_q%0d", i - 1), q, vec030[i - 1]);
            check($sformatf("st_usedw%0d", i), 32'(usedw), 32'd1);
        end
        wrreq = 1'b0;
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        check("st_q3", q, vec030[3]);
        check("st_empty", 32'(rdempty), 32'd1);
        check("st_usedw_end", 32'(usedw), 32'd0);

        // Read when empty holds q (0x10); wr+rd when empty writes only.
        pop();
        check("er_q_hold", q, 32'h10);
        check("er_usedw", 32'(usedw), 32'd0);
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = 32'h55;
        tick();
        idle();
        check("ewr_usedw", 32'(usedw), 32'd1);
        check("ewr_q_hold", q, 32'h10);
        pop();
        check("ewr_q", q, 32'h55);
        check("ewr_empty", 32'(rdempty), 32'd1);

        // Fill to DEPTH (pointers wrap), overflow write, drain in order.
        for (int i = 0; i < int'(DEPTH); i++) push(32'(i));
        check("full_wrfull", 32'(wrfull), 32'd1);
        check("full_usedw", 32'(usedw), DEPTH);
        push(32'hDEAD);
        check("ovf_usedw", 32'(usedw), DEPTH);
        check("ovf_wrfull", 32'(wrfull), 32'd1);
        // Write while full is ignored even alongside an accepted read.
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = 32'hBEEF;
        tick();
        idle();
        check("fwr_q", q, 32'd0);
        check("fwr_usedw", 32'(usedw), DEPTH - 1);
        check("fwr_wrfull", 32'(wrfull), 32'd0);
        for (int i = 1; i < int'(DEPTH); i++) begin
            pop();
            check($sformatf("drain_q%0d", i), q, 32'(i));
        end
        check("drain_empty", 32'(rdempty), 32'd1);
        check("drain_usedw", 32'(usedw), 32'd0);

        // Clear with three words stored, concurrent with a write.
        push(32'h1);
        push(32'h2);
        push(32'h3);
        check("pre_clr_usedw", 32'(usedw), 32'd3);
        aclr  = 1'b1;
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = 32'h77;
        tick();
        idle();
        check("clr_usedw", 32'(usedw), 32'd0);
        check("clr_rdempty", 32'(rdempty), 32'd1);
        check("clr_wrfull", 32'(wrfull), 32'd0);
        check("clr_q", q, 32'd0);
        push(32'h99);
        check("post_clr_usedw", 32'(usedw), 32'd1);
        pop();
        check("post_clr_q", q, 32'h99);
        check("post_clr_empty", 32'(rdempty), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcfifo.md
DCFIFO -- requirements
Module: dcfifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width; 4 for the instruction path.
REQ-002 The block SHALL have parameter DEPTH, default 512, word capacity; power of two, at least 4.
REQ-003 The block SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port aclr  input  1  clear; one clock, reset is synchronous and active-high.
REQ-005 The block SHALL have port wrreq  input  1  write request; samples data at the edge.
REQ-006 The block SHALL have port data  input  WIDTH  write data.
REQ-007 The block SHALL have port wrfull  output  1  high when occupancy equals DEPTH.
REQ-008 The block SHALL have port rdreq  input  1  read request.
REQ-009 The block SHALL have port q  output  WIDTH  read data.
REQ-010 The block SHALL have port rdempty  output  1  high when occupancy is 0.
REQ-011 The block SHALL have port usedw  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-012 Storage SHALL be a DEPTH-entry memory with write and read pointers, each wrapping modulo DEPTH.
REQ-013 A write SHALL be accepted at an edge with wrreq=1 and wrfull=0: data stored at the write pointer, pointer +1.
REQ-014 wrreq with wrfull=1 SHALL be ignored (no store, no pointer or usedw change), including when rdreq is also high.
REQ-015 A read SHALL be accepted at an edge with rdreq=1 and rdempty=0: read pointer +1.
REQ-016 rdreq with rdempty=1 SHALL be ignored and q SHALL hold its value, including when wrreq is also high.
REQ-017 In normal mode, q SHALL be a register loaded with the head word at the edge that accepts a read, so the word is valid one cycle after rdreq and held until the next accepted read.
REQ-018 usedw SHALL update at the same edge as an accepted operation: +1 for write only, -1 for read only, unchanged when both are accepted.
REQ-019 wrfull, rdempty and usedw SHALL be registered and reflect occupancy after each edge, with zero added latency; a word written at edge N is readable by rdreq sampled at edge N+1.
REQ-020 Data SHALL leave in write order, with no loss or duplication across pointer wrap-around.

Reset
REQ-021 When aclr=1 at an edge: pointers and usedw SHALL become 0, rdempty=1, wrfull=0, q=0, and contents SHALL be discarded.
REQ-022 wrreq and rdreq SHALL be ignored at any edge where aclr=1.
REQ-023 Normal operation SHALL resume at the first edge with aclr=0.
REQ-024 A reset mid-operation SHALL discard all stored words, with no partial state kept.

Configuration
REQ-025 Macro DCFIFO_SHOWAHEAD_EN, when defined, SHALL select show-ahead mode.
REQ-026 In show-ahead mode, q SHALL present the head word whenever rdempty=0, with no read needed; rdreq acts as acknowledge and q shows the next word one cycle later.
REQ-027 In show-ahead mode, q SHALL equal 0 while empty after reset.
REQ-028 Without DCFIFO_SHOWAHEAD_EN, normal mode per REQ-017 SHALL apply, and REQ-026/027 logic SHALL be absent.

Verification
REQ-029 WIDTH=4, after reset: write 2,3,0,0 on four cycles -> usedw=4, rdempty=0, wrfull=0; four single-cycle reads -> q=2,3,0,0 each one cycle after its rdreq; then rdempty=1, usedw=0.
REQ-030 WIDTH=32: write 4,16,16,16 back to back while reading each word on the cycle after its write -> q sequence 4,16,16,16; usedw never exceeds 1; ends empty.
REQ-031 Write 512 words (value = index) -> wrfull=1, usedw=512; 513th write ignored; read all -> 0..511 in order; rdempty=1.
REQ-032 Read when empty with q=0x0000_0010 -> q unchanged, usedw=0; simultaneous wrreq+rdreq when empty -> write only, usedw=1.
REQ-033 With 3 words stored, assert aclr for one cycle concurrent with wrreq -> usedw=0, rdempty=1, q=0; the next write/read returns the new word.
REQ-034 With DCFIFO_SHOWAHEAD_EN: write 0xA then 0xB -> q=0xA with no rdreq; one rdreq -> q=0xB next cycle.
